alu_core: RTL
=============

// Module: alu_core
// PURPOSE
//  Parametrised, registered ALU replacing the combinational 8-bit adder in the datapath.
//  Operand A comes from the accumulator and operand B from the bus.
//  Supports add/sub/logic/shift in 1 cycle and unsigned multiply by iterative shift-add (WIDTH cycles).
//  Valid/ready on both sides; result and flags (C, Z, N, V) are held until consumed by bus/status register.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2); MUL iteration count = WIDTH
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operand/op request valid
//  in_ready   out  1      request accepted on edge where in_valid && in_ready
//  op         in   3      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 MUL
//  in_a       in   WIDTH  operand A (accumulator)
//  in_b       in   WIDTH  operand B (bus)
//  cin        in   1      carry in (ADD only)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result on edge where out_valid && out_ready
//  out_sum    out  WIDTH  result (MUL: low half of product)
//  out_hi     out  WIDTH  MUL: high half of product; 0 for all other ops
//  cout       out  1      carry flag
//  zero       out  1      zero flag
//  neg        out  1      negative flag = out_sum[WIDTH-1]
//  ovf        out  1      signed overflow flag
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0; out_sum, out_hi, cout, zero, neg, ovf = 0; iteration counter = 0.
//  Reset mid-MUL aborts: no out_valid, partial product discarded.
//  FSM states: IDLE, MUL, DONE. in_ready = (state==IDLE) || (state==DONE && out_ready).
//  Accept (in_valid && in_ready):
//   op!=MUL -> compute, register result/flags, go to DONE.
//   op==MUL -> latch A/B, clear accumulator, go to MUL.
//  MUL: one shift-add step per cycle; counter 0..WIDTH-1; at WIDTH-1 register product/flags, go DONE.
//  Latency from accept edge to out_valid high: 1 cycle (non-MUL), WIDTH+1 cycles (MUL).
//  DONE: out_valid=1; all outputs stable while !out_ready.
//   out_ready && !in_valid -> IDLE.
//   out_ready && in_valid -> retire current result and accept new op on the same edge (back-to-back, no bubble).
//  In MUL, in_ready=0 and in_valid/op/operands are ignored.
//  Arithmetic, all modulo 2^WIDTH:
//   ADD: {cout,sum} = A+B+cin; ovf = (A[msb]==B[msb]) && (sum[msb]!=A[msb]).
//   SUB: sum = A-B (cin ignored); cout = 1 when A>=B unsigned (no borrow); ovf = (A[msb]!=B[msb]) && (sum[msb]!=A[msb]).
//   AND/OR/XOR: cout=0, ovf=0.
//   SHL: sum = A<<1, cout = A[msb]. SHR: logical, sum = A>>1, cout = A[0]. ovf=0 for both.
//   MUL: unsigned {out_hi,out_sum} = A*B; cout = |out_hi; ovf=0; zero = full 2*WIDTH product == 0.
//  zero (non-MUL) = (out_sum==0); out_hi = 0 for non-MUL ops.
//  in_ready is 1 while rst is high (state forced IDLE); no request is accepted during reset.
// TESTING (WIDTH=8 unless noted)
//  ADD A=FF B=01 cin=0 -> out_sum=00 cout=1 zero=1 ovf=0; out_valid exactly 1 cycle after accept.
//  SUB A=80 B=01 -> out_sum=7F cout=1 ovf=1 neg=0; SUB A=01 B=02 -> out_sum=FF cout=0 neg=1.
//  MUL A=FF B=FF -> out_hi=FE out_sum=01 cout=1; out_valid 9 cycles after accept; in_ready=0 during MUL.
//  Backpressure: hold out_ready=0 for 5 cycles after ADD result, toggle in_valid/operands
//   -> outputs unchanged, no accept; then out_ready=1 + in_valid(XOR AA^0F)
//   -> back-to-back accept, next result A5 one cycle later.
//  Reset asserted on 4th MUL cycle -> out_valid=0, all outputs 0 immediately;
//   after release, SHL A=81 -> out_sum=02 cout=1.
//  WIDTH=16 random sweep of all ops vs reference model, random in_valid/out_ready -> zero mismatches, no lost/duplicated results.

Source files
------------

// File: rtl/alu_if.sv
// Purpose : request/response bundle between the datapath and alu_core.
// Latency : n/a (wires only).
// Backpressure : in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports   : master = requester/consumer (drives op, operands, out_ready);
//           slave  = alu_core (drives in_ready, result and flags).
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [WIDTH-1:0] out_hi;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, op, in_a, in_b, cin, out_ready,
    input  in_ready, out_valid, out_sum, out_hi, cout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, op, in_a, in_b, cin, out_ready,
    output in_ready, out_valid, out_sum, out_hi, cout, zero, neg, ovf
  );
endinterface

// File: rtl/alu_core.sv
// Purpose : registered ALU (add/sub/and/or/xor/shl/shr) plus iterative unsigned shift-add multiply.
// Latency : 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL (accept edge to out_valid).
// Backpressure : result and flags held while out_valid && !out_ready; a new op is accepted on the
//                same edge the old result retires; no request accepted while a MUL is iterating.
// Ports   : clk, rst (async, active-high); bus = alu_if.slave (request, result, flags C/Z/N/V).
module alu_core #(
  parameter int WIDTH = 8
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mul_a, acc_hi, acc_lo;
  logic [WIDTH-1:0] sum_q, hi_q;
  logic             c_q, z_q, n_q, v_q;
  logic             accept;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   wide;
  logic [WIDTH:0]   step_add;
  logic [2*WIDTH-1:0] step_prod;

  assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_hi    = hi_q;
  assign bus.cout      = c_q;
  assign bus.zero      = z_q;
  assign bus.neg       = n_q;
  assign bus.ovf       = v_q;

  // Single-cycle ops; the extra top bit of 'wide' is carry (ADD) or borrow (SUB).
  always_comb begin
    alu_sum = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    case (bus.op)
      OP_ADD: begin
        wide    = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, bus.cin};
        alu_sum = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus.in_a[MSB] == bus.in_b[MSB]) && (alu_sum[MSB] != bus.in_a[MSB]);
      end
      OP_SUB: begin
        wide    = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        alu_sum = wide[WIDTH-1:0];
        alu_c   = ~wide[WIDTH];
        alu_v   = (bus.in_a[MSB] != bus.in_b[MSB]) && (alu_sum[MSB] != bus.in_a[MSB]);
      end
      OP_AND: alu_sum = bus.in_a & bus.in_b;
      OP_OR:  alu_sum = bus.in_a | bus.in_b;
      OP_XOR: alu_sum = bus.in_a ^ bus.in_b;
      OP_SHL: begin
        alu_sum = {bus.in_a[WIDTH-2:0], 1'b0};
        alu_c   = bus.in_a[MSB];
      end
      OP_SHR: begin
        alu_sum = {1'b0, bus.in_a[WIDTH-1:1]};
        alu_c   = bus.in_a[0];
      end
      default: ;
    endcase
  end

  // One shift-add step: multiplier bits are consumed from acc_lo LSB-first while the
  // partial product shifts in from the top, so {acc_hi, acc_lo} ends as the full product.
  always_comb begin
    step_add  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mul_a} : {(WIDTH+1){1'b0}});
    step_prod = {step_add, acc_lo[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    if ((state == S_DONE) && bus.out_ready) state_nxt = S_IDLE;
    if (accept) state_nxt = (bus.op == OP_MUL) ? S_MUL : S_DONE;
    if ((state == S_MUL) && (cnt == CNT_LAST)) state_nxt = S_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mul_a  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      sum_q  <= '0;
      hi_q   <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
    end else if (accept) begin
      if (bus.op == OP_MUL) begin
        mul_a  <= bus.in_a;
        acc_lo <= bus.in_b;
        acc_hi <= '0;
        cnt    <= '0;
      end else begin
        sum_q <= alu_sum;
        hi_q  <= '0;
        c_q   <= alu_c;
        z_q   <= (alu_sum == '0);
        n_q   <= alu_sum[MSB];
        v_q   <= alu_v;
      end
    end else if (state == S_MUL) begin
      acc_hi <= step_prod[2*WIDTH-1:WIDTH];
      acc_lo <= step_prod[WIDTH-1:0];
      if (cnt == CNT_LAST) begin
        // Last step: publish the product directly from the step result.
        cnt   <= '0;
        sum_q <= step_prod[WIDTH-1:0];
        hi_q  <= step_prod[2*WIDTH-1:WIDTH];
        c_q   <= |step_prod[2*WIDTH-1:WIDTH];
        z_q   <= (step_prod == '0);
        n_q   <= step_prod[MSB];
        v_q   <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule
